hazard_stall_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage ARMv8 core.
- Generates write enables and flushes for the PC register, the IF/ID register, the ID/EX register and the EX/MEM register.
- Handles three events: load-use hazards, taken branches resolved in MEM, and instruction-memory wait states.
- Keeps a flush-penalty FSM, a fetch-timeout watchdog and a saturating stall-cycle performance counter.

---
 rtl/hazard_stall_ctrl_if.sv | 30 +++
 rtl/hazard_stall_ctrl.sv | 120 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-facing signal bundle of the hazard/stall sequencer.
// The master is the pipeline side. The slave is the sequencer.
interface hazard_stall_ctrl_if;
    logic [31:0] id_instr;
    logic        ex_memread;
    logic [4:0]  ex_rd;
    logic        mem_branch_taken;
    logic        imem_ready;
    logic        pc_wren;
    logic        pc_sel_branch;
    logic        if_id_wren;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        ex_mem_flush;
    logic        fetch_error;
    logic [15:0] stall_cycles;
    logic [1:0]  state;

    modport master (
        output id_instr, ex_memread, ex_rd, mem_branch_taken, imem_ready,
        input  pc_wren, pc_sel_branch, if_id_wren, if_id_flush, id_ex_bubble,
               ex_mem_flush, fetch_error, stall_cycles, state
    );

    modport slave (
        input  id_instr, ex_memread, ex_rd, mem_branch_taken, imem_ready,
        output pc_wren, pc_sel_branch, if_id_wren, if_id_flush, id_ex_bubble,
               ex_mem_flush, fetch_error, stall_cycles, state
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Central sequencer for the 5-stage core.
// It issues PC and pipeline-register enables and flushes for load-use, taken-branch and fetch-wait events.
module hazard_stall_ctrl #(
    parameter int BR_PENALTY   = 1,
    parameter int IMEM_TIMEOUT = 64
) (
    input logic clock,
    input logic reset,
    hazard_stall_ctrl_if.slave bus
);
    localparam logic [1:0]  RUN       = 2'd0;
    localparam logic [1:0]  FLUSH     = 2'd1;
    localparam logic [1:0]  IMEM_WAIT = 2'd2;
    localparam logic [3:0]  PENALTY   = 4'(BR_PENALTY);
    localparam logic [15:0] TIMEOUT   = 16'(IMEM_TIMEOUT);

    function automatic logic [15:0] sat_inc(input logic [15:0] value, input logic [15:0] limit);
        return (value >= limit) ? limit : value + 16'd1;
    endfunction

    logic [1:0]  state_q, state_d;
    logic [3:0]  flush_cnt_q, flush_cnt_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        fetch_error_q, fetch_error_d;
    logic [15:0] stall_q;
    logic        rt_is_src, hz;
    logic        pc_wren, pc_sel_branch, if_id_wren, if_id_flush, id_ex_bubble, ex_mem_flush;

    // Rt is only read as a source by stores and compare-and-branch.
    always_comb begin
        rt_is_src = (bus.id_instr[31:21] == 11'h7C0) || (bus.id_instr[31:24] == 8'hB4);
        hz = bus.ex_memread && (bus.ex_rd != 5'd31) &&
             ((bus.ex_rd == bus.id_instr[9:5]) ||
              (bus.ex_rd == bus.id_instr[20:16]) ||
              (rt_is_src && (bus.ex_rd == bus.id_instr[4:0])));
    end

    always_comb begin
        pc_wren       = 1'b1;
        pc_sel_branch = 1'b0;
        if_id_wren    = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_flush  = 1'b0;
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        fetch_error_d = fetch_error_q;
        if (reset) begin
            pc_wren      = 1'b0;
            if_id_wren   = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (bus.mem_branch_taken) begin
            pc_sel_branch = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            ex_mem_flush  = 1'b1;
            state_d       = (PENALTY == 4'd0) ? RUN : FLUSH;
            flush_cnt_d   = PENALTY;
            wait_cnt_d    = 16'd0;
        end else if (state_q == FLUSH) begin
            // IF/ID holds a NOP while the redirected fetch is outstanding, so load-use cannot occur.
            pc_wren     = bus.imem_ready;
            if_id_flush = 1'b1;
            if (bus.imem_ready) begin
                flush_cnt_d = flush_cnt_q - 4'd1;
                if (flush_cnt_q <= 4'd1) begin
                    flush_cnt_d = 4'd0;
                    state_d     = RUN;
                end
            end
        end else if (hz) begin
            pc_wren      = 1'b0;
            if_id_wren   = 1'b0;
            id_ex_bubble = 1'b1;
            state_d      = (state_q == IMEM_WAIT) ? IMEM_WAIT : RUN;
        end else if (!bus.imem_ready) begin
            pc_wren     = 1'b0;
            if_id_flush = 1'b1;
            state_d     = IMEM_WAIT;
            wait_cnt_d  = (state_q == IMEM_WAIT) ? sat_inc(wait_cnt_q, TIMEOUT) : 16'd1;
            if (wait_cnt_d >= TIMEOUT) begin
                fetch_error_d = 1'b1;
            end
        end else begin
            state_d    = RUN;
            wait_cnt_d = 16'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= RUN;
            flush_cnt_q   <= 4'd0;
            wait_cnt_q    <= 16'd0;
            fetch_error_q <= 1'b0;
            stall_q       <= 16'd0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            fetch_error_q <= fetch_error_d;
            if (!pc_wren) begin
                stall_q <= sat_inc(stall_q, 16'hFFFF);
            end
        end
    end

    assign bus.pc_wren       = pc_wren;
    assign bus.pc_sel_branch = pc_sel_branch;
    assign bus.if_id_wren    = if_id_wren;
    assign bus.if_id_flush   = if_id_flush;
    assign bus.id_ex_bubble  = id_ex_bubble;
    assign bus.ex_mem_flush  = ex_mem_flush;
    assign bus.fetch_error   = fetch_error_q;
    assign bus.stall_cycles  = stall_q;
    assign bus.state         = state_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl.
// A rule-level model is checked every cycle, and literal expectations pin key points of the sequence.
module tb_hazard_stall_ctrl;
    localparam int BR_PEN  = 1;
    localparam int TIMEOUT = 4;

    localparam logic [31:0] I_NOP   = 32'h8B000000;
    localparam logic [31:0] I_ADD3  = 32'h8B040065;
    localparam logic [31:0] I_ADDZ  = 32'h8B0403E5;
    localparam logic [31:0] I_CBZ7  = 32'hB4000007;
    localparam logic [31:0] I_ADD7  = 32'h8B000007;
    localparam logic [31:0] I_STUR9 = 32'hF8000049;

    localparam int M_RUN = 0, M_FLUSH = 1, M_WAIT = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    hazard_stall_ctrl_if bus();

    hazard_stall_ctrl #(.BR_PENALTY(BR_PEN), .IMEM_TIMEOUT(TIMEOUT)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // The model holds the sequencer's situation as plain integers.
    int m_mode = M_RUN;
    int m_pen = 0;
    int m_wait = 0;
    int m_err = 0;
    int m_stalls = 0;

    function automatic bit model_hz(input logic mr, input logic [4:0] rd, input logic [31:0] ins);
        int srcs[$];
        if (!mr || rd == 5'd31) return 1'b0;
        srcs.push_back(int'(ins[9:5]));
        srcs.push_back(int'(ins[20:16]));
        if (ins[31:21] == 11'h7C0 || ins[31:24] == 8'hB4) srcs.push_back(int'(ins[4:0]));
        foreach (srcs[i]) if (srcs[i] == int'(rd)) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge clock) begin : compare
        bit e_pcw, e_sel, e_ifw, e_iff, e_bub, e_exf, h;
        chk("state", 32'(bus.state), 32'(m_mode));
        chk("fetch_error", 32'(bus.fetch_error), 32'(m_err));
        chk("stall_cycles", 32'(bus.stall_cycles), 32'(m_stalls));
        h = model_hz(bus.ex_memread, bus.ex_rd, bus.id_instr);
        e_pcw = 1; e_sel = 0; e_ifw = 1; e_iff = 0; e_bub = 0; e_exf = 0;
        if (reset) begin
            e_pcw = 0; e_ifw = 0; e_iff = 1; e_bub = 1; e_exf = 1;
            m_mode = M_RUN; m_pen = 0; m_wait = 0; m_err = 0; m_stalls = 0;
        end else if (bus.mem_branch_taken) begin
            e_sel = 1; e_iff = 1; e_bub = 1; e_exf = 1;
            m_mode = (BR_PEN == 0) ? M_RUN : M_FLUSH;
            m_pen = BR_PEN;
            m_wait = 0;
        end else if (m_mode == M_FLUSH) begin
            e_pcw = bus.imem_ready; e_iff = 1;
            if (bus.imem_ready) begin
                m_pen = m_pen - 1;
                if (m_pen <= 0) m_mode = M_RUN;
            end
        end else if (h) begin
            e_pcw = 0; e_ifw = 0; e_bub = 1;
        end else if (!bus.imem_ready) begin
            e_pcw = 0; e_iff = 1;
            m_wait = (m_mode == M_WAIT) ? ((m_wait + 1 > TIMEOUT) ? TIMEOUT : m_wait + 1) : 1;
            if (m_wait >= TIMEOUT) m_err = 1;
            m_mode = M_WAIT;
        end else begin
            m_mode = M_RUN;
            m_wait = 0;
        end
        if (!reset && !e_pcw && m_stalls < 65535) m_stalls++;
        chk("pc_wren", 32'(bus.pc_wren), 32'(e_pcw));
        chk("pc_sel_branch", 32'(bus.pc_sel_branch), 32'(e_sel));
        chk("if_id_wren", 32'(bus.if_id_wren), 32'(e_ifw));
        chk("if_id_flush", 32'(bus.if_id_flush), 32'(e_iff));
        chk("id_ex_bubble", 32'(bus.id_ex_bubble), 32'(e_bub));
        chk("ex_mem_flush", 32'(bus.ex_mem_flush), 32'(e_exf));
    end

    task automatic cyc(input logic rst, input logic br, input logic rdy,
                       input logic mr, input logic [4:0] rd, input logic [31:0] ins);
        @(posedge clock);
        #1;
        reset = rst;
        bus.mem_branch_taken = br;
        bus.imem_ready = rdy;
        bus.ex_memread = mr;
        bus.ex_rd = rd;
        bus.id_instr = ins;
        @(negedge clock);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, I_NOP);
    endtask

    initial begin
        bus.mem_branch_taken = 1'b0;
        bus.imem_ready = 1'b1;
        bus.ex_memread = 1'b0;
        bus.ex_rd = 5'd0;
        bus.id_instr = I_NOP;

        cyc(1, 0, 1, 0, 0, I_NOP);
        cyc(1, 0, 1, 0, 0, I_NOP);
        chk("lit_rst_state", 32'(bus.state), 0);
        chk("lit_rst_pcw", 32'(bus.pc_wren), 0);
        chk("lit_rst_iff", 32'(bus.if_id_flush), 1);
        chk("lit_rst_stall", 32'(bus.stall_cycles), 0);
        idle();
        chk("lit_run_pcw", 32'(bus.pc_wren), 1);

        // Load-use hazards: Rn match, XZR, CBZ Rt, ADD with a matching Rd, STUR Rt
        cyc(0, 0, 1, 1, 5'd3, I_ADD3);
        chk("lit_lu_pcw", 32'(bus.pc_wren), 0);
        chk("lit_lu_ifw", 32'(bus.if_id_wren), 0);
        chk("lit_lu_bub", 32'(bus.id_ex_bubble), 1);
        idle();
        chk("lit_lu_pcw_after", 32'(bus.pc_wren), 1);
        chk("lit_lu_stall", 32'(bus.stall_cycles), 1);
        cyc(0, 0, 1, 1, 5'd31, I_ADDZ);
        chk("lit_xzr_pcw", 32'(bus.pc_wren), 1);
        cyc(0, 0, 1, 1, 5'd7, I_CBZ7);
        chk("lit_cbz_pcw", 32'(bus.pc_wren), 0);
        cyc(0, 0, 1, 1, 5'd7, I_ADD7);
        chk("lit_add_rt_pcw", 32'(bus.pc_wren), 1);
        cyc(0, 0, 1, 1, 5'd9, I_STUR9);
        chk("lit_stur_pcw", 32'(bus.pc_wren), 0);
        idle();
        chk("lit_stall3", 32'(bus.stall_cycles), 3);

        // A taken branch, with one cycle of flush penalty
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, I_NOP);
        chk("lit_br_sel", 32'(bus.pc_sel_branch), 1);
        chk("lit_br_exf", 32'(bus.ex_mem_flush), 1);
        chk("lit_br_bub", 32'(bus.id_ex_bubble), 1);
        idle();
        chk("lit_flush_state", 32'(bus.state), 1);
        chk("lit_flush_iff", 32'(bus.if_id_flush), 1);
        idle();
        chk("lit_back_run", 32'(bus.state), 0);

        // The branch wins over a concurrent hazard, and the hazard is ignored during FLUSH
        cyc(0, 1, 1, 1, 5'd3, I_ADD3);
        chk("lit_brhz_pcw", 32'(bus.pc_wren), 1);
        chk("lit_brhz_sel", 32'(bus.pc_sel_branch), 1);
        cyc(0, 0, 1, 1, 5'd3, I_ADD3);
        chk("lit_flushhz_state", 32'(bus.state), 1);
        chk("lit_flushhz_bub", 32'(bus.id_ex_bubble), 0);
        idle();

        // Three fetch wait cycles
        cyc(0, 0, 0, 0, 5'd0, I_NOP);
        chk("lit_w0_state", 32'(bus.state), 0);
        chk("lit_w0_pcw", 32'(bus.pc_wren), 0);
        cyc(0, 0, 0, 0, 5'd0, I_NOP);
        chk("lit_w1_state", 32'(bus.state), 2);
        cyc(0, 0, 0, 0, 5'd0, I_NOP);
        idle();
        chk("lit_w3_state", 32'(bus.state), 2);
        chk("lit_w3_pcw", 32'(bus.pc_wren), 1);
        idle();
        chk("lit_w_done_state", 32'(bus.state), 0);
        chk("lit_w_done_err", 32'(bus.fetch_error), 0);
        chk("lit_stall6", 32'(bus.stall_cycles), 6);

        // A branch arrives while in IMEM_WAIT
        cyc(0, 0, 0, 0, 5'd0, I_NOP);
        cyc(0, 0, 0, 0, 5'd0, I_NOP);
        cyc(0, 1, 0, 0, 5'd0, I_NOP);
        chk("lit_wbr_state", 32'(bus.state), 2);
        chk("lit_wbr_pcw", 32'(bus.pc_wren), 1);
        idle();
        chk("lit_wbr_flush", 32'(bus.state), 1);
        idle();
        chk("lit_stall8", 32'(bus.stall_cycles), 8);

        // Fetch timeout, then clearing by reset
        repeat (4) cyc(0, 0, 0, 0, 5'd0, I_NOP);
        chk("lit_to_err_pre", 32'(bus.fetch_error), 0);
        cyc(0, 0, 0, 0, 5'd0, I_NOP);
        chk("lit_to_err", 32'(bus.fetch_error), 1);
        idle();
        chk("lit_to_stall", 32'(bus.stall_cycles), 13);
        idle();
        chk("lit_to_sticky", 32'(bus.fetch_error), 1);
        cyc(1, 0, 1, 0, 0, I_NOP);
        chk("lit_rst2_bub", 32'(bus.id_ex_bubble), 1);
        idle();
        chk("lit_rst2_state", 32'(bus.state), 0);
        chk("lit_rst2_err", 32'(bus.fetch_error), 0);
        chk("lit_rst2_stall", 32'(bus.stall_cycles), 0);

        // FLUSH holds while the fetch is not ready
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, I_NOP);
        cyc(0, 0, 0, 0, 5'd0, I_NOP);
        chk("lit_fw_state", 32'(bus.state), 1);
        chk("lit_fw_pcw", 32'(bus.pc_wren), 0);
        idle();
        chk("lit_fw_state2", 32'(bus.state), 1);
        idle();
        chk("lit_fw_run", 32'(bus.state), 0);
        chk("lit_fw_stall", 32'(bus.stall_cycles), 1);

        // Reset in the middle of IMEM_WAIT
        cyc(0, 0, 0, 0, 5'd0, I_NOP);
        cyc(0, 0, 0, 0, 5'd0, I_NOP);
        chk("lit_mw_state", 32'(bus.state), 2);
        cyc(1, 0, 0, 0, 0, I_NOP);
        idle();
        chk("lit_mw_rst_state", 32'(bus.state), 0);
        chk("lit_mw_rst_pcw", 32'(bus.pc_wren), 1);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
